// File: rtl/serial_adder_pkg.sv
`default_nettype none
// ============================================================================
// Module      : serial_adder_pkg
// Description : Shared constants and types for the bit-serial adder: state
//               encodings, state enum, default operand width and a helper
//               that sizes the bit counter.
// Revision    : 1.0 - initial release
// ============================================================================
package serial_adder_pkg;

    // Default operand/result width in bits.
    localparam int DEFAULT_WIDTH = 8;

    // State encodings.
    localparam logic [1:0] c_st_idle = 2'd0;
    localparam logic [1:0] c_st_run  = 2'd1;
    localparam logic [1:0] c_st_done = 2'd2;

    typedef enum logic [1:0] {
        IDLE = c_st_idle,
        RUN  = c_st_run,
        DONE = c_st_done
    } state_t;

    // Bit-counter width: $clog2(width), never less than one bit.
    function automatic int cnt_width(input int width);
        int w;
        w = $clog2(width);
        return (w < 1) ? 1 : w;
    endfunction

endpackage : serial_adder_pkg
`default_nettype wire

// File: rtl/fa_bit.sv
`default_nettype none
// ============================================================================
// Module      : fa_bit
// Description : One-bit combinational full adder (a + b + ci -> s, co).
//               The single arithmetic cell shared by every bit position of
//               the serial adder.
// Revision    : 1.0 - initial release
// ============================================================================
module fa_bit (
    input  logic a_i,
    input  logic b_i,
    input  logic ci_i,
    output logic s_o,
    output logic co_o
);

    // Sum and majority carry.
    assign s_o  = a_i ^ b_i ^ ci_i;
    assign co_o = (a_i & b_i) | (a_i & ci_i) | (b_i & ci_i);

endmodule : fa_bit
`default_nettype wire

// File: rtl/serial_adder.sv
`default_nettype none
// ============================================================================
// Module      : serial_adder
// Description : Bit-serial WIDTH-bit adder. Operands are captured on an
//               accepted start, then one bit per clock (LSB first) passes
//               through a single full-adder cell whose carry recirculates
//               through a flip-flop. The finished result is copied to the
//               held outputs sum_o/co_o on the completion edge.
//               Optional feature macro: SERIAL_ADDER_SUB_EN adds a sub_i
//               port that turns the operation into a - b (two's complement).
// Revision    : 1.0 - initial release
// ============================================================================
module serial_adder
    import serial_adder_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start_i,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    input  logic             ci_i,
`ifdef SERIAL_ADDER_SUB_EN
    input  logic             sub_i,
`endif
    output logic             busy_o,
    output logic             done_o,
    output logic [WIDTH-1:0] sum_o,
    output logic             co_o
);

    localparam int              CW     = cnt_width(WIDTH);
    localparam logic [CW-1:0]   c_last = CW'(WIDTH - 1);

    state_t            state_q, state_d;
    logic [WIDTH-1:0]  a_sr_q,  a_sr_d;
    logic [WIDTH-1:0]  b_sr_q,  b_sr_d;
    // Holds the WIDTH-1 result bits already produced; the last bit comes
    // straight from the cell on the completion edge.
    logic [WIDTH-2:0]  res_sr_q, res_sr_d;
    logic              carry_q, carry_d;
    logic [CW-1:0]     cnt_q,   cnt_d;
    logic [WIDTH-1:0]  sum_q,   sum_d;
    logic              co_q,    co_d;
`ifdef SERIAL_ADDER_SUB_EN
    logic              sub_q,   sub_d;
`endif

    logic              cell_b;
    logic              cell_s;
    logic              cell_co;
    logic [WIDTH-1:0]  res_shift;
    logic              accept;

    // Subtraction inverts each b bit on its way into the cell.
`ifdef SERIAL_ADDER_SUB_EN
    assign cell_b = b_sr_q[0] ^ sub_q;
`else
    assign cell_b = b_sr_q[0];
`endif

    fa_bit u_fa_bit (
        .a_i  (a_sr_q[0]),
        .b_i  (cell_b),
        .ci_i (carry_q),
        .s_o  (cell_s),
        .co_o (cell_co)
    );

    // New sum bit enters at the MSB; the top WIDTH-1 bits become the new
    // partial result, and the full vector is the final result on the last bit.
    assign res_shift = {cell_s, res_sr_q};

    // A request is only honoured outside RUN.
    assign accept = start_i && (state_q != RUN);

    // Next-state, datapath and result-update logic.
    always_comb begin
        state_d  = state_q;
        a_sr_d   = a_sr_q;
        b_sr_d   = b_sr_q;
        res_sr_d = res_sr_q;
        carry_d  = carry_q;
        cnt_d    = cnt_q;
        sum_d    = sum_q;
        co_d     = co_q;
`ifdef SERIAL_ADDER_SUB_EN
        sub_d    = sub_q;
`endif

        case (state_q)
            IDLE: begin
                state_d = IDLE;
            end
            RUN: begin
                a_sr_d   = {1'b0, a_sr_q[WIDTH-1:1]};
                b_sr_d   = {1'b0, b_sr_q[WIDTH-1:1]};
                res_sr_d = res_shift[WIDTH-1:1];
                carry_d  = cell_co;
                if (cnt_q == c_last) begin
                    sum_d   = res_shift;
                    co_d    = cell_co;
                    state_d = DONE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Accepted request (from IDLE or DONE) overrides the above.
        if (accept) begin
            a_sr_d   = a_i;
            b_sr_d   = b_i;
            res_sr_d = '0;
            carry_d  = ci_i;
            cnt_d    = '0;
            state_d  = RUN;
`ifdef SERIAL_ADDER_SUB_EN
            sub_d    = sub_i;
            if (sub_i) begin
                carry_d = 1'b1;
            end
`endif
        end
    end

    // State and datapath registers; reset discards any partial result.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            a_sr_q   <= '0;
            b_sr_q   <= '0;
            res_sr_q <= '0;
            carry_q  <= 1'b0;
            cnt_q    <= '0;
            sum_q    <= '0;
            co_q     <= 1'b0;
`ifdef SERIAL_ADDER_SUB_EN
            sub_q    <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            a_sr_q   <= a_sr_d;
            b_sr_q   <= b_sr_d;
            res_sr_q <= res_sr_d;
            carry_q  <= carry_d;
            cnt_q    <= cnt_d;
            sum_q    <= sum_d;
            co_q     <= co_d;
`ifdef SERIAL_ADDER_SUB_EN
            sub_q    <= sub_d;
`endif
        end
    end

    assign busy_o = (state_q == RUN);
    assign done_o = (state_q == DONE);
    assign sum_o  = sum_q;
    assign co_o   = co_q;

endmodule : serial_adder
`default_nettype wire

// File: tb/tb_serial_adder.sv
`default_nettype none
// ============================================================================
// Module      : tb_serial_adder
// Description : Self-checking bench for serial_adder. Stimulus pushes the
//               hand-computed {co, sum} into a queue; a monitor pops and
//               compares whenever done is presented.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_serial_adder;

    localparam int WIDTH = 8;

    logic             clk = 1'b0;
    logic             rst;
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             ci;
`ifdef SERIAL_ADDER_SUB_EN
    logic             sub;
`endif
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] sum;
    logic             co;

    int checks = 0;
    int errors = 0;

    logic [WIDTH:0] exp_q[$];
    logic [WIDTH:0] exp_e;

    serial_adder #(.WIDTH(WIDTH)) dut (
        .clk     (clk),
        .rst     (rst),
        .start_i (start),
        .a_i     (a),
        .b_i     (b),
        .ci_i    (ci),
`ifdef SERIAL_ADDER_SUB_EN
        .sub_i   (sub),
`endif
        .busy_o  (busy),
        .done_o  (done),
        .sum_o   (sum),
        .co_o    (co)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Counts edges until busy drops, bounded.
    task automatic wait_done(output int n);
        n = 0;
        while (busy === 1'b1 && n < WIDTH + 4) begin
            tick();
            n++;
        end
    endtask

    // Scoreboard monitor: every done pulse must match the oldest expectation.
    always @(negedge clk) begin
        if (rst === 1'b0 && done === 1'b1) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_done actual sum=%0h co=%0b required no done", sum, co);
            end else begin
                exp_e = exp_q.pop_front();
                check("result_sum", 32'(sum), 32'(exp_e[WIDTH-1:0]));
                check("result_co",  32'(co),  32'(exp_e[WIDTH]));
            end
        end
    end

    // One full operation with busy-length and done-pulse checks.
    task automatic run_op(input logic [WIDTH-1:0] ta, input logic [WIDTH-1:0] tb,
                          input logic tci, input logic [WIDTH-1:0] esum, input logic eco);
        int n;
        a     = ta;
        b     = tb;
        ci    = tci;
        start = 1'b1;
        exp_q.push_back({eco, esum});
        tick();
        start = 1'b0;
        check("busy_after_start", 32'(busy), 32'd1);
        wait_done(n);
        check("busy_cycles", 32'(n), 32'(WIDTH));
        check("done_pulse", 32'(done), 32'd1);
        tick();
        check("done_cleared", 32'(done), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout checks=%0d", checks);
        $fatal(1);
    end

    initial begin
        int n;
        int done_seen;
        rst   = 1'b1;
        start = 1'b0;
        a     = '0;
        b     = '0;
        ci    = 1'b0;
`ifdef SERIAL_ADDER_SUB_EN
        sub   = 1'b0;
`endif
        tick();
        tick();
        check("reset_busy", 32'(busy), 32'd0);
        check("reset_done", 32'(done), 32'd0);
        check("reset_sum",  32'(sum),  32'd0);
        check("reset_co",   32'(co),   32'd0);
        rst = 1'b0;
        tick();

        // Directed vectors.
        run_op(8'h00, 8'h00, 1'b0, 8'h00, 1'b0);
        run_op(8'hFF, 8'h01, 1'b0, 8'h00, 1'b1);
        run_op(8'h80, 8'h80, 1'b1, 8'h01, 1'b1);
        run_op(8'h3C, 8'h0F, 1'b0, 8'h4B, 1'b0);
        tick();

        // Back-to-back: start held through DONE, no IDLE gap; operand
        // changes and start during RUN have no effect on the first run.
        a     = 8'h5A;
        b     = 8'hA5;
        ci    = 1'b1;
        start = 1'b1;
        exp_q.push_back({1'b1, 8'h00});
        tick();
        a  = 8'h12;
        b  = 8'h34;
        ci = 1'b0;
        check("b2b_busy", 32'(busy), 32'd1);
        wait_done(n);
        check("b2b_busy_cycles", 32'(n), 32'(WIDTH));
        check("b2b_done", 32'(done), 32'd1);
        exp_q.push_back({1'b0, 8'h46});
        tick();
        check("b2b_no_idle_gap", 32'(busy), 32'd1);
        check("b2b_done_low", 32'(done), 32'd0);
        start = 1'b0;
        wait_done(n);
        check("b2b_second_cycles", 32'(n), 32'(WIDTH));
        tick();

        // Start pulsed mid-run is ignored; sum holds the previous result.
        a     = 8'h0F;
        b     = 8'h01;
        ci    = 1'b0;
        start = 1'b1;
        exp_q.push_back({1'b0, 8'h10});
        tick();
        start = 1'b0;
        tick();
        tick();
        check("sum_held_mid_run", 32'(sum), 32'h46);
        a     = 8'hF0;
        b     = 8'hF0;
        start = 1'b1;
        tick();
        start = 1'b0;
        wait_done(n);
        check("ignored_start_cycles", 32'(n), 32'(WIDTH - 3));
        check("ignored_start_done", 32'(done), 32'd1);
        tick();
        tick();

        // Reset in the 4th RUN cycle: outputs clear at once, no done.
        a     = 8'h55;
        b     = 8'h22;
        ci    = 1'b0;
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        tick();
        tick();
        check("pre_reset_busy", 32'(busy), 32'd1);
        rst = 1'b1;
        #1;
        check("async_rst_busy", 32'(busy), 32'd0);
        check("async_rst_done", 32'(done), 32'd0);
        check("async_rst_sum",  32'(sum),  32'd0);
        check("async_rst_co",   32'(co),   32'd0);
        tick();
        rst = 1'b0;
        done_seen = 0;
        for (int i = 0; i < WIDTH + 3; i++) begin
            tick();
            if (done === 1'b1 || busy === 1'b1) done_seen++;
        end
        check("no_done_after_reset", 32'(done_seen), 32'd0);
        run_op(8'h03, 8'h04, 1'b0, 8'h07, 1'b0);

`ifdef SERIAL_ADDER_SUB_EN
        sub = 1'b1;
        run_op(8'h10, 8'h01, 1'b0, 8'h0F, 1'b1);
        run_op(8'h01, 8'h02, 1'b1, 8'hFF, 1'b0);
        sub = 1'b0;
        run_op(8'h01, 8'h02, 1'b1, 8'h04, 1'b0);
`endif

        tick();
        check("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_serial_adder
`default_nettype wire
